// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the fetch PC, issues one outstanding imem request
// at a time and registers each response onto the IF/ID boundary.
module fetch_sequencer #(
  parameter int               XLEN     = 64,
  parameter int               IMEM_AW  = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_addr,
  input  logic                stall,
  output logic                imem_req,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [XLEN-1:0]     if_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] req_pc, req_pc_next;
  logic            discard, discard_next;
  logic            valid_next;
  logic [31:0]     instr_next;
  logic [XLEN-1:0] ifpc_next;
  logic            accept;

  assign imem_addr = pc[IMEM_AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      discard  <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= NOP;
      if_pc    <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_pc   <= req_pc_next;
      discard  <= discard_next;
      if_valid <= valid_next;
      if_instr <= instr_next;
      if_pc    <= ifpc_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    req_pc_next  = req_pc;
    discard_next = discard;
    valid_next   = if_valid;
    instr_next   = if_instr;
    ifpc_next    = if_pc;
    // A stalled ID stage must not see a new request land behind its held instruction
    imem_req     = (state == REQ) && !stall;
    accept       = imem_req && imem_ready;

    if (if_valid && !stall) valid_next = 1'b0;

    unique case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (accept) begin
          state_next  = WAIT;
          req_pc_next = pc;
          pc_next     = pc + XLEN'(4);
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (discard) begin
            discard_next = 1'b0;
            state_next   = REQ;
          end else begin
            instr_next = imem_rdata;
            ifpc_next  = req_pc;
            valid_next = 1'b1;
            state_next = stall ? HOLD : REQ;
          end
        end
      end
      HOLD: if (!stall) state_next = REQ;
      default: state_next = IDLE;
    endcase

    // Redirect wins; a response still owed by memory must be swallowed in WAIT
    if (redirect_valid) begin
      pc_next    = redirect_addr & ~XLEN'(3);
      valid_next = 1'b0;
      instr_next = if_instr;
      ifpc_next  = if_pc;
      if ((state == WAIT && !imem_rvalid) || accept) begin
        discard_next = 1'b1;
        state_next   = WAIT;
      end else begin
        discard_next = 1'b0;
        state_next   = REQ;
      end
    end
  end

endmodule
